// File: rtl/gfx_pkg.sv
// Shared definitions for the planar pixel fetch path: palette field layout,
// channel levels, fetch FSM states and the palette-byte decoder.
package gfx_pkg;

  localparam int unsigned EN_LSB = 4;
  localparam int unsigned BR_LSB = 0;
  localparam logic [7:0] LVL_FULL = 8'hff;
  localparam logic [7:0] LVL_HALF = 8'h80;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} fetch_state_e;

  // Palette byte -> {red, green, blue}; channel k enable at EN_LSB+k, bright at BR_LSB+k.
  function automatic logic [23:0] decode_rgb(input logic [7:0] p);
    logic [23:0] rgb;
    rgb = '0;
    for (int k = 0; k < 3; k++) begin
      if (p[EN_LSB + k]) rgb[23 - 8 * k -: 8] = p[BR_LSB + k] ? LVL_FULL : LVL_HALF;
    end
    return rgb;
  endfunction

endpackage

// File: rtl/gfx_pal_resolve.sv
// Combinational colour resolve: ORs palette bytes of set bg and fg planes, then
// picks fg per channel whenever its level is nonzero.
module gfx_pal_resolve
  import gfx_pkg::*;
#(
  parameter int unsigned PLANES = 6
) (
  input  logic [PLANES-1:0]   bits_i,
  input  logic [PLANES*8-1:0] pal_i,
  output logic [7:0]          red_o,
  output logic [7:0]          green_o,
  output logic [7:0]          blue_o
);

  logic [7:0]  bg_pal, fg_pal;
  logic [23:0] bg_rgb, fg_rgb, out_rgb;

  always_comb begin
    bg_pal = '0;
    fg_pal = '0;
    for (int i = 0; i < PLANES; i++) begin
      if (bits_i[i]) begin
        if (i < PLANES / 2) bg_pal = bg_pal | pal_i[i * 8 +: 8];
        else                fg_pal = fg_pal | pal_i[i * 8 +: 8];
      end
    end
    bg_rgb = decode_rgb(bg_pal);
    fg_rgb = decode_rgb(fg_pal);
    for (int k = 0; k < 3; k++) begin
      out_rgb[k * 8 +: 8] = (fg_rgb[k * 8 +: 8] != 8'h00) ? fg_rgb[k * 8 +: 8]
                                                         : bg_rgb[k * 8 +: 8];
    end
  end

  assign red_o   = out_rgb[23:16];
  assign green_o = out_rgb[15:8];
  assign blue_o  = out_rgb[7:0];

endmodule

// File: rtl/gfx_planar_fetch.sv
// Bitplane pixel generator: fetches PLANES bytes per 8-pixel cell, serialises them and
// outputs registered RGB. Define GFX_BORDER_EN to drive the border colour outside de.
module gfx_planar_fetch
  import gfx_pkg::*;
#(
  parameter int unsigned PLANES    = 6,
  parameter int unsigned ACT_W     = 192,
  parameter int unsigned ACT_H     = 184,
  parameter int unsigned VRAM_BASE = 'hec0,
  parameter int unsigned AW        = 13,
  parameter int unsigned PW        = $clog2(PLANES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic [8:0]          h,
  input  logic [8:0]          v,
  output logic [AW-1:0]       vram_addr,
  output logic [PW-1:0]       vram_plane,
  output logic                vram_rd,
  input  logic                vram_valid,
  input  logic [7:0]          vram_data,
  input  logic [PLANES*8-1:0] pal,
  input  logic [PLANES-1:0]   mask,
  input  logic [7:0]          border,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic                de,
  output logic                underrun
);

  localparam int unsigned CELLS = ACT_W / 8;
  localparam logic [8:0] ActW9  = 9'(ACT_W);
  localparam logic [8:0] ActH9  = 9'(ACT_H);
  localparam logic [8:0] DeEnd9 = 9'(ACT_W + 8);

  fetch_state_e             state_q;
  logic [PW-1:0]            plane_q;
  logic [AW-1:0]            addr_q;
  logic                     pend_q;
  logic [PLANES-1:0][7:0]   stage_q, shift_q, stage_eff;
  logic                     underrun_q, de_q;
  logic [7:0]               red_q, green_q, blue_q;

  logic                     bnd, start, take, last, incomplete, de_next;
  logic [AW-1:0]            addr_next;
  logic [PLANES-1:0]        pix_bits;
  logic [7:0]               pix_r, pix_g, pix_b;
  logic [23:0]              idle_rgb;

  assign bnd        = ce_pix && (h[2:0] == 3'd0);
  assign start      = bnd && (h < ActW9) && (v < ActH9);
  assign take       = (state_q == StWait) && vram_valid;
  assign last       = (plane_q == PW'(PLANES - 1));
  // A last-plane return landing on the boundary edge still counts as finished.
  assign incomplete = (state_q == StReq) || ((state_q == StWait) && !(take && last));
  assign de_next    = (h >= 9'd8) && (h < DeEnd9) && (v < ActH9);
  assign addr_next  = AW'(VRAM_BASE + 32'(v) * CELLS + 32'(h[8:3]));
  // Hold off a new request while an aborted one is still outstanding.
  assign vram_rd    = (state_q == StReq) && !pend_q;

  always_comb begin
    stage_eff = stage_q;
    if (take) stage_eff[plane_q] = vram_data;
    for (int p = 0; p < PLANES; p++) begin
      pix_bits[p] = bnd ? stage_eff[p][0] : shift_q[p][0];
    end
    pix_bits = pix_bits & mask;
  end

  gfx_pal_resolve #(
    .PLANES (PLANES)
  ) u_resolve (
    .bits_i  (pix_bits),
    .pal_i   (pal),
    .red_o   (pix_r),
    .green_o (pix_g),
    .blue_o  (pix_b)
  );

`ifdef GFX_BORDER_EN
  assign idle_rgb = decode_rgb(border);
`else
  logic unused_border;
  assign unused_border = ^border;
  assign idle_rgb      = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      plane_q    <= '0;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      stage_q    <= '0;
      shift_q    <= '0;
      underrun_q <= 1'b0;
      de_q       <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      if (vram_rd)         pend_q <= 1'b1;
      else if (vram_valid) pend_q <= 1'b0;

      if (bnd) begin
        for (int p = 0; p < PLANES; p++) shift_q[p] <= stage_eff[p] >> 1;
        stage_q <= '0;
        plane_q <= '0;
        if (incomplete) underrun_q <= 1'b1;
        if (start) begin
          state_q <= StReq;
          addr_q  <= addr_next;
        end else begin
          state_q <= StIdle;
        end
      end else begin
        if (ce_pix) begin
          for (int p = 0; p < PLANES; p++) shift_q[p] <= shift_q[p] >> 1;
        end
        if (take) stage_q[plane_q] <= vram_data;
        case (state_q)
          StReq:  if (vram_rd) state_q <= StWait;
          StWait: begin
            if (vram_valid) begin
              state_q <= last ? StDone : StReq;
              if (!last) plane_q <= plane_q + PW'(1);
            end
          end
          default: ;
        endcase
      end

      if (ce_pix) begin
        de_q    <= de_next;
        red_q   <= de_next ? pix_r : idle_rgb[23:16];
        green_q <= de_next ? pix_g : idle_rgb[15:8];
        blue_q  <= de_next ? pix_b : idle_rgb[7:0];
      end
    end
  end

  assign vram_addr  = addr_q;
  assign vram_plane = plane_q;
  assign underrun   = underrun_q;
  assign de         = de_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;

endmodule

// File: tb/tb_gfx_planar_fetch.sv
// Scoreboard bench for gfx_planar_fetch: a VRAM responder model, directed cells with
// hand-computed pixel colours queued up front, and a monitor checking each de pixel.
module tb_gfx_planar_fetch;

  localparam int unsigned PLANES = 6;

  logic                clk = 1'b0;
  logic                reset, ce_pix;
  logic [8:0]          h, v;
  logic [12:0]         vram_addr;
  logic [2:0]          vram_plane;
  logic                vram_rd, vram_valid;
  logic [7:0]          vram_data;
  logic [PLANES*8-1:0] pal;
  logic [PLANES-1:0]   mask;
  logic [7:0]          border, red, green, blue;
  logic                de, underrun;

  always #5 clk = ~clk;

  gfx_planar_fetch u_dut (
    .clk        (clk),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .h          (h),
    .v          (v),
    .vram_addr  (vram_addr),
    .vram_plane (vram_plane),
    .vram_rd    (vram_rd),
    .vram_valid (vram_valid),
    .vram_data  (vram_data),
    .pal        (pal),
    .mask       (mask),
    .border     (border),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .de         (de),
    .underrun   (underrun)
  );

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          rd_cnt = 0;
  logic [7:0]  pdata [PLANES];
  logic [7:0]  rsp_data;
  logic [12:0] first_addr;
  logic [2:0]  first_plane;
  logic [23:0] exp_q [$];
  logic [23:0] exp_px;
  logic        ce_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // VRAM model: answers each read strobe after lat clocks with the plane's byte.
  initial begin
    vram_valid = 1'b0;
    vram_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (vram_rd && !reset) begin
        if (rd_cnt == 0) begin
          first_addr  = vram_addr;
          first_plane = vram_plane;
        end
        rd_cnt++;
        rsp_data = pdata[vram_plane];
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1 vram_valid = 1'b1;
        vram_data = rsp_data;
        @(posedge clk);
        #1 vram_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) ce_seen <= ce_pix && !reset;

  // Monitor: every freshly registered de pixel is matched against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (ce_seen && de) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got pixel %0h with no expected entry", {red, green, blue});
        end else begin
          exp_px = exp_q.pop_front();
          check("pixel", 32'({red, green, blue}), 32'(exp_px));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int div);
    ce_pix = 1'b1;
    @(posedge clk);
    #1 ce_pix = 1'b0;
    h = h + 9'd1;
    repeat (div - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_h(input int last_h, input int div);
    while (int'(h) <= last_h) step(div);
  endtask

  task automatic clear_cfg();
    pal    = '0;
    mask   = '1;
    border = 8'h00;
    for (int p = 0; p < PLANES; p++) pdata[p] = 8'h00;
  endtask

  task automatic set_plane(input int p, input logic [7:0] data, input logic [7:0] pv);
    pdata[p]       = data;
    pal[p * 8 +: 8] = pv;
  endtask

  task automatic do_reset();
    ce_pix = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    h = 9'd0;
    v = 9'd0;
    rd_cnt = 0;
  endtask

  // Queue one cell: x0 and x1 given, x2..x6 black, x7 given.
  task automatic push_cell(input logic [23:0] x0, input logic [23:0] x1,
                           input logic [23:0] x7);
    exp_q.push_back(x0);
    exp_q.push_back(x1);
    for (int i = 2; i < 7; i++) exp_q.push_back(24'h0);
    exp_q.push_back(x7);
  endtask

  initial begin
    reset  = 1'b1;
    ce_pix = 1'b0;
    h      = 9'd0;
    v      = 9'd0;
    clear_cfg();
    repeat (2) @(posedge clk);
    #1;
    check("rst_red", 32'(red), 32'h0);
    check("rst_green", 32'(green), 32'h0);
    check("rst_blue", 32'(blue), 32'h0);
    check("rst_de", 32'(de), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_rd", 32'(vram_rd), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset while waiting on plane 0; its late return must not restart anything.
    lat = 6;
    step(2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rd_after_reset", 32'(vram_rd), 32'h0);
    repeat (12) @(posedge clk);
    #1;
    check("stale_rd_count", 32'(rd_cnt), 32'd1);
    check("stale_underrun", 32'(underrun), 32'h0);

    // Single bg plane, red bright at leftmost pixel.
    h = 9'd0;
    v = 9'd0;
    rd_cnt = 0;
    lat = 1;
    set_plane(0, 8'h01, 8'h11);
    push_cell(24'hff0000, 24'h0, 24'h0);
    run_h(15, 2);
    check("t2_addr", 32'(first_addr), 32'hec0);
    check("t2_plane", 32'(first_plane), 32'h0);
    check("t2_underrun", 32'(underrun), 32'h0);

    // fg bright red over bg half red wins; bg alone at x1.
    do_reset();
    clear_cfg();
    lat = 1;
    set_plane(0, 8'h03, 8'h10);
    set_plane(3, 8'h01, 8'h11);
    push_cell(24'hff0000, 24'h800000, 24'h0);
    run_h(15, 2);

    // Masked plane 1 with all bits set contributes nothing.
    do_reset();
    clear_cfg();
    lat = 1;
    mask = 6'b000001;
    set_plane(0, 8'h01, 8'h11);
    set_plane(1, 8'hff, 8'h77);
    push_cell(24'hff0000, 24'h0, 24'h0);
    run_h(15, 2);

    // Slow memory: only planes 0..2 arrive before the next cell boundary.
    do_reset();
    clear_cfg();
    lat = 9;
    set_plane(0, 8'h01, 8'h11);
    set_plane(3, 8'hff, 8'h22);
    set_plane(4, 8'hff, 8'h22);
    set_plane(5, 8'hff, 8'h22);
    push_cell(24'hff0000, 24'h0, 24'h0);
    run_h(8, 4);
    check("t5_underrun", 32'(underrun), 32'h1);
    run_h(15, 4);
    check("t5_underrun_sticky", 32'(underrun), 32'h1);

    // Last plane returns on the very boundary edge: captured, no underrun.
    do_reset();
    clear_cfg();
    lat = 3;
    set_plane(5, 8'h80, 8'h44);
    push_cell(24'h0, 24'h0, 24'h0000ff);
    run_h(15, 3);
    check("t7_underrun", 32'(underrun), 32'h0);

    // Address of cell 2 on line 5, then border behaviour outside the active area.
    do_reset();
    clear_cfg();
    lat = 1;
    v = 9'd5;
    h = 9'd16;
    exp_q.push_back(24'h0);
    step(2);
    repeat (4) @(posedge clk);
    #1;
    check("t6_addr", 32'(first_addr), 32'hf3a);
    check("t6_plane", 32'(first_plane), 32'h0);
    border = 8'h32;
    v = 9'd190;
    h = 9'd20;
    step(2);
    check("t6_de", 32'(de), 32'h0);
`ifdef GFX_BORDER_EN
    check("t6_border", 32'({red, green, blue}), 32'h80ff00);
`else
    check("t6_border", 32'({red, green, blue}), 32'h0);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
